// File: rtl/hps_design_pio_pwm_if.sv
// Avalon-MM register bus for the PIO-gated PWM block.
// Zero-wait-state: readdata is combinational from address.
interface hps_design_pio_pwm_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/hps_design_pio_pwm.sv
// PWM/blink generator gated by the PIO out_port bit, with its own Avalon-MM register slave.
// Period and duty are shadowed and only reloaded at a period boundary.
module hps_design_pio_pwm #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned DEFAULT_PERIOD = 1000,
  parameter int unsigned DEFAULT_DUTY   = 500
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable_in,
  hps_design_pio_pwm_if.slave       bus,
  output logic                      led_out
);

  localparam logic [CNT_W-1:0] PeriodRst = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DutyRst   = CNT_W'(DEFAULT_DUTY);

  typedef enum logic {StIdle, StRun} state_t;

  // Registers
  state_t           r_state;
  logic             r_soft_en;
  logic             r_invert;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per_sh;
  logic [CNT_W-1:0] r_duty_sh;
  logic [15:0]      r_wraps;
  logic             r_led;

  // Combinational
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_per_sh_nxt;
  logic [CNT_W-1:0] w_duty_sh_nxt;
  logic [15:0]      w_wraps_nxt;
  logic             w_led_nxt;
  logic             w_wr;
  logic             w_run;
  logic             w_wrap;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_wr  = bus.chipselect & ~bus.write_n;
  assign w_run = enable_in & r_soft_en;

  // per_sh of 0 or 1 must wrap every cycle; avoid the underflow of per_sh-1.
  assign w_wrap = (r_per_sh <= CNT_W'(1)) || (r_cnt >= (r_per_sh - CNT_W'(1)));

  assign w_unused_wdata = ^bus.writedata[31:CNT_W];

  // Register file writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_soft_en <= 1'b0;
      r_invert  <= 1'b0;
      r_period  <= PeriodRst;
      r_duty    <= DutyRst;
    end else if (w_wr) begin
      unique case (bus.address)
        2'd0: begin
          r_soft_en <= bus.writedata[0];
          r_invert  <= bus.writedata[1];
        end
        2'd1:    r_period <= bus.writedata[CNT_W-1:0];
        2'd2:    r_duty   <= bus.writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_per_sh_nxt  = r_per_sh;
    w_duty_sh_nxt = r_duty_sh;
    w_wraps_nxt   = r_wraps;
    unique case (r_state)
      StIdle: begin
        if (w_run) begin
          w_state_nxt   = StRun;
          w_cnt_nxt     = '0;
          w_per_sh_nxt  = r_period;
          w_duty_sh_nxt = r_duty;
        end
      end
      StRun: begin
        // Stopping beats a coincident wrap, so wraps is not bumped.
        if (!w_run) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else if (w_wrap) begin
          w_cnt_nxt     = '0;
          w_wraps_nxt   = r_wraps + 16'd1;
          w_per_sh_nxt  = r_period;
          w_duty_sh_nxt = r_duty;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_wr && (bus.address == 2'd3)) begin
      w_wraps_nxt = '0;
    end
  end

  assign w_led_nxt = ((r_state == StRun) ? (r_cnt < r_duty_sh) : 1'b0) ^ r_invert;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_per_sh  <= PeriodRst;
      r_duty_sh <= DutyRst;
      r_wraps   <= '0;
      r_led     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_per_sh  <= w_per_sh_nxt;
      r_duty_sh <= w_duty_sh_nxt;
      r_wraps   <= w_wraps_nxt;
      r_led     <= w_led_nxt;
    end
  end

  assign led_out = r_led;

  always_comb begin
    w_rdata = '0;
    unique case (bus.address)
      2'd0:    w_rdata = {30'd0, r_invert, r_soft_en};
      2'd1:    w_rdata = 32'(r_period);
      2'd2:    w_rdata = 32'(r_duty);
      2'd3:    w_rdata = {r_wraps, 15'd0, (r_state == StRun)};
      default: w_rdata = '0;
    endcase
  end

  assign bus.readdata = w_rdata;

endmodule
